ssd_scan: RTL and testbench

SSD_SCAN -- requirements
Module: ssd_scan

---
 rtl/ssd_scan.sv | 152 +++++++++++++++
 tb/tb_ssd_scan.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ssd_scan.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking,
// frame-synchronous display update and optional leading-zero suppression.
module ssd_scan #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  output logic [3:0]  position,
  output logic [7:0]  pattern,
  output logic        frame_done
);

  localparam int unsigned     CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      index_q, index_d;
  logic [15:0]     act_dig_q, act_dig_d;
  logic [3:0]      act_dp_q, act_dp_d;
  logic [15:0]     pend_dig_q, pend_dig_d;
  logic [3:0]      pend_dp_q, pend_dp_d;
  logic            pend_valid_q, pend_valid_d;
  logic [3:0]      position_q, position_d;
  logic [7:0]      pattern_q, pattern_d;
  logic            frame_done_q, frame_done_d;

  logic            slot_end;
  logic            boundary;
  logic [3:0]      nibble;
  logic            zero_lead;
  logic            suppress;

  // Active-low segments a..g, MSB = a.
  function automatic logic [6:0] hex7seg(input logic [3:0] h);
    logic [6:0] seg;
    unique case (h)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  always_comb begin
    slot_end = (cnt_q == CntMax);
    boundary = slot_end && (index_q == 2'd3);

    cnt_d   = slot_end ? '0 : cnt_q + CntW'(1);
    index_d = slot_end ? index_q + 2'd1 : index_q;

    state_d = state_q;
    unique case (state_q)
      StBlank: if (cnt_d == BlankEnd) state_d = StShow;
      StShow:  if (slot_end) state_d = StBlank;
      default: state_d = StBlank;
    endcase

    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (boundary && pend_valid_q) begin
      act_dig_d    = pend_dig_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    // A load on the boundary edge still lands in pending after the old value moves out.
    if (load) begin
      pend_dig_d   = digits;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end

    // Outputs are registered from next-state values so they line up with the slot counter.
    nibble    = 4'h0;
    zero_lead = 1'b0;
    unique case (index_d)
      2'd0: begin nibble = act_dig_d[3:0];   zero_lead = 1'b0;                  end
      2'd1: begin nibble = act_dig_d[7:4];   zero_lead = (act_dig_d[15:4] == '0); end
      2'd2: begin nibble = act_dig_d[11:8];  zero_lead = (act_dig_d[15:8] == '0); end
      2'd3: begin nibble = act_dig_d[15:12]; zero_lead = (act_dig_d[15:12] == '0); end
      default: begin nibble = 4'h0; zero_lead = 1'b0; end
    endcase
    suppress = LZ_BLANK && zero_lead;

    position_d = 4'hF;
    pattern_d  = 8'hFF;
    if (state_d == StShow) begin
      position_d = ~(4'b0001 << index_d);
      pattern_d  = {(suppress ? 7'h7F : hex7seg(nibble)), ~act_dp_d[index_d]};
    end

    frame_done_d = (cnt_d == CntMax) && (index_d == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      index_q      <= 2'd0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      position_q   <= 4'hF;
      pattern_q    <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      index_q      <= index_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      position_q   <= position_d;
      pattern_q    <= pattern_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign position   = position_q;
  assign pattern    = pattern_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan.sv
// Directed bench for ssd_scan with SCAN_DIV=8, BLANK_CYC=2; a second instance runs LZ_BLANK=0.
module tb_ssd_scan;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  position, position_n;
  logic [7:0]  pattern, pattern_n;
  logic        frame_done, frame_done_n;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  ssd_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits     (digits),
    .dp         (dp),
    .position   (position),
    .pattern    (pattern),
    .frame_done (frame_done)
  );

  ssd_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1'b0)) dut_nolz (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits     (digits),
    .dp         (dp),
    .position   (position_n),
    .pattern    (pattern_n),
    .frame_done (frame_done_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // cyc tracks the slot-counter position since the last reset release.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load   = 1'b1;
    digits = d;
    dp     = p;
    tick();
    load   = 1'b0;
  endtask

  task automatic show_chk(input string tag, input logic [3:0] pos, input logic [7:0] pat);
    check_val({tag, "_pos"}, 32'(position), 32'(pos));
    check_val({tag, "_pat"}, 32'(pattern), 32'(pat));
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    digits = '0;
    dp     = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      show_chk("rst", 4'hF, 8'hFF);
      check_val("rst_fd", 32'(frame_done), 32'd0);
    end
    rst_n = 1'b1;
    cyc   = 0;

    show_chk("c0_blank", 4'hF, 8'hFF);
    goto(1); show_chk("c1_blank", 4'hF, 8'hFF);
    goto(2); show_chk("c2_show", 4'hE, 8'h03);
    goto(3); do_load(16'h1234, 4'h0);
    goto(5); show_chk("f0_d0_old", 4'hE, 8'h03);
    goto(7); show_chk("c7_show", 4'hE, 8'h03);
    goto(28); show_chk("f0_d3_lz", 4'h7, 8'hFF);
    goto(30); check_val("fd_30", 32'(frame_done), 32'd0);
    goto(31); check_val("fd_31", 32'(frame_done), 32'd1);
    goto(32); check_val("fd_32", 32'(frame_done), 32'd0);
    goto(36); show_chk("f1_d0", 4'hE, 8'h99);
    goto(44); show_chk("f1_d1", 4'hD, 8'h0D);
    goto(52); show_chk("f1_d2", 4'hB, 8'h25);
    goto(60); show_chk("f1_d3", 4'h7, 8'h9F);

    // Free run: frame pulse every 32 cycles, two blank cycles at every slot start.
    goto(64);
    for (int i = 0; i < 100; i++) begin
      check_val("run_fd", 32'(frame_done), 32'((cyc % 32) == 31));
      check_val("run_blank", 32'(position == 4'hF), 32'((cyc % 8) < 2));
      tick();
    end

    goto(165); do_load(16'h0050, 4'h0);
    goto(196); show_chk("lz_d0", 4'hE, 8'h03);
    goto(204); show_chk("lz_d1", 4'hD, 8'h49);
    goto(212); show_chk("lz_d2", 4'hB, 8'hFF);
    check_val("nolz_d2", 32'(pattern_n), 32'h03);
    goto(220); show_chk("lz_d3", 4'h7, 8'hFF);
    check_val("nolz_d3_pat", 32'(pattern_n), 32'h03);
    check_val("nolz_d3_pos", 32'(position_n), 32'h7);

    goto(226); do_load(16'h1111, 4'h0);
    goto(228); show_chk("f7_d0", 4'hE, 8'h03);
    goto(240); do_load(16'h2222, 4'h4);
    goto(260); show_chk("ovr_d0", 4'hE, 8'h25);
    goto(268); show_chk("ovr_d1", 4'hD, 8'h25);
    goto(276); show_chk("ovr_d2", 4'hB, 8'h24);
    goto(284); show_chk("ovr_d3", 4'h7, 8'h25);

    goto(287); do_load(16'h8888, 4'h0);
    goto(292); show_chk("bnd_wait", 4'hE, 8'h25);
    goto(324); show_chk("bnd_show", 4'hE, 8'h01);

    goto(330); do_load(16'h4444, 4'h0);
    goto(351); do_load(16'h5555, 4'h0);
    goto(356); show_chk("bnd_xfer_old", 4'hE, 8'h99);
    goto(388); show_chk("bnd_xfer_new", 4'hE, 8'h49);

    // One-cycle reset during the digit2 show window.
    goto(404);
    show_chk("pre_rst_d2", 4'hB, 8'h49);
    rst_n = 1'b0;
    tick();
    show_chk("mid_rst", 4'hF, 8'hFF);
    check_val("mid_rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    show_chk("post_c0", 4'hF, 8'hFF);
    goto(1);  show_chk("post_c1", 4'hF, 8'hFF);
    goto(2);  show_chk("post_d0", 4'hE, 8'h03);
    goto(12); show_chk("post_d1", 4'hD, 8'hFF);
    goto(30); check_val("post_fd30", 32'(frame_done), 32'd0);
    goto(31); check_val("post_fd31", 32'(frame_done), 32'd1);
    goto(36); show_chk("post_f1_d0", 4'hE, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
